// File: rtl/sha_schedule_pkg.sv
// Shared types and helpers for SHA-256 message-schedule expansion.
package sha_schedule_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BLOCK_WORDS   = 16;
    localparam int unsigned T_W           = 6;
    localparam int unsigned SHA256_ROUNDS = 64;

    typedef logic [WORD_W-1:0]                   word_t;
    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0]  block_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // Small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_schedule_controller_if.sv
// Block-in / word-out handshake bundle of the schedule controller.
interface sha_schedule_controller_if;
    import sha_schedule_pkg::*;

    logic                 blk_valid_i;
    logic                 blk_ready_o;
    block_t               blk_i;
    logic                 w_valid_o;
    logic                 w_ready_i;
    word_t                w_o;
    logic [T_W-1:0]       t_o;
    logic                 last_o;
    logic                 busy_o;
    logic                 done_o;

    // Controller side
    modport slave (
        input  blk_valid_i, blk_i, w_ready_i,
        output blk_ready_o, w_valid_o, w_o, t_o, last_o, busy_o, done_o
    );

    // Producer/consumer side
    modport master (
        output blk_valid_i, blk_i, w_ready_i,
        input  blk_ready_o, w_valid_o, w_o, t_o, last_o, busy_o, done_o
    );

endinterface

// File: rtl/sha_schedule_step.sv
// One expansion step: W_{t+16} from the 16-word window holding W_t..W_{t+15}.
module sha_schedule_step
    import sha_schedule_pkg::*;
(
    input  block_t win_i,
    output word_t  next_o
);

    // Window taps not used by the recurrence
    logic unused_taps;
    assign unused_taps = ^{win_i[15], win_i[13:10], win_i[8:2]};

    // Recurrence, mod 2^32
    assign next_o = sigma1(win_i[14]) + win_i[9] + sigma0(win_i[1]) + win_i[0];

endmodule

// File: rtl/sha_schedule_controller.sv
// Accepts a 512-bit block and streams W_0..W_{ROUNDS-1} under backpressure.
module sha_schedule_controller
    import sha_schedule_pkg::*;
#(
    parameter int unsigned ROUNDS       = SHA256_ROUNDS,
    parameter bit          BACK_TO_BACK = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    sha_schedule_controller_if.slave   bus
);

    localparam logic [T_W-1:0] T_LAST = T_W'(ROUNDS - 1);

    state_e          state_q;
    block_t          win_q;
    word_t           w_q;
    logic [T_W-1:0]  t_q;
    logic            last_q;
    logic            done_q;
    logic            pend_q;
    word_t           next_w;
    logic            blk_ready;
    logic            beat;
    logic            accept;

    sha_schedule_step u_step (
        .win_i  (win_q),
        .next_o (next_w)
    );

    // Block acceptance window: idle, or the final word when chaining blocks.
    // pend_q blocks a second acceptance while a stalled last word still waits.
    assign blk_ready = (state_q == IDLE) ||
                       (BACK_TO_BACK && (state_q == RUN) && last_q && !pend_q);
    assign beat      = (state_q == RUN) && bus.w_ready_i;
    assign accept    = bus.blk_valid_i && blk_ready;

    // Sequencer: window shift, round counter, block chaining and done pulse.
    // A block accepted while the last word is stalled is parked in the window;
    // the displayed word lives in w_q so it survives until its beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            w_q     <= '0;
            t_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_q   <= bus.blk_i;
                        w_q     <= bus.blk_i[0];
                        t_q     <= '0;
                        last_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (!last_q) begin
                            win_q  <= {next_w, win_q[15:1]};
                            w_q    <= win_q[1];
                            t_q    <= t_q + T_W'(1);
                            last_q <= ((t_q + T_W'(1)) == T_LAST);
                        end else begin
                            done_q <= 1'b1;
                            if (pend_q) begin
                                w_q    <= win_q[0];
                                t_q    <= '0;
                                last_q <= 1'b0;
                                pend_q <= 1'b0;
                            end else if (accept) begin
                                win_q  <= bus.blk_i;
                                w_q    <= bus.blk_i[0];
                                t_q    <= '0;
                                last_q <= 1'b0;
                            end else begin
                                last_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end else if (accept) begin
                        win_q  <= bus.blk_i;
                        pend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.blk_ready_o = blk_ready;
    assign bus.w_valid_o   = (state_q == RUN);
    assign bus.busy_o      = (state_q == RUN);
    assign bus.w_o         = w_q;
    assign bus.t_o         = t_q;
    assign bus.last_o      = last_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_sha_schedule_controller.sv
// Randomised bench for both chaining modes against a FIPS-style schedule model.
module tb_sha_schedule_controller;
    import sha_schedule_pkg::*;

    localparam int unsigned ROUNDS = 64;
    localparam int NDUT = 2;
    localparam int QD   = 4096;
    localparam int MAXB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_schedule_controller_if if0 ();
    sha_schedule_controller_if if1 ();

    sha_schedule_controller #(.ROUNDS(ROUNDS), .BACK_TO_BACK(1'b1)) u_dut_b2b (
        .clk (clk), .rst (rst), .bus (if0)
    );
    sha_schedule_controller #(.ROUNDS(ROUNDS), .BACK_TO_BACK(1'b0)) u_dut_gap (
        .clk (clk), .rst (rst), .bus (if1)
    );

    logic        drv_valid [NDUT];
    block_t      drv_blk   [NDUT];
    logic        drv_rdy   [NDUT];
    logic        mon_valid [NDUT];
    logic        mon_ready [NDUT];
    logic [31:0] mon_w     [NDUT];
    logic [5:0]  mon_t     [NDUT];
    logic        mon_last  [NDUT];
    logic        mon_busy  [NDUT];
    logic        mon_done  [NDUT];

    assign if0.blk_valid_i = drv_valid[0];
    assign if0.blk_i       = drv_blk[0];
    assign if0.w_ready_i   = drv_rdy[0];
    assign if1.blk_valid_i = drv_valid[1];
    assign if1.blk_i       = drv_blk[1];
    assign if1.w_ready_i   = drv_rdy[1];
    assign mon_valid[0] = if0.w_valid_o;   assign mon_valid[1] = if1.w_valid_o;
    assign mon_ready[0] = if0.blk_ready_o; assign mon_ready[1] = if1.blk_ready_o;
    assign mon_w[0]     = if0.w_o;         assign mon_w[1]     = if1.w_o;
    assign mon_t[0]     = if0.t_o;         assign mon_t[1]     = if1.t_o;
    assign mon_last[0]  = if0.last_o;      assign mon_last[1]  = if1.last_o;
    assign mon_busy[0]  = if0.busy_o;      assign mon_busy[1]  = if1.busy_o;
    assign mon_done[0]  = if0.done_o;      assign mon_done[1]  = if1.done_o;

    int errors = 0;
    int checks = 0;

    // Expected word stream per DUT (index = position in stream)
    logic [31:0] exp_w [NDUT][QD];
    int          exp_t [NDUT][QD];
    int          exp_wr [NDUT];
    int          exp_rd [NDUT];
    logic        pend_done [NDUT];
    int          done_cnt [NDUT];

    block_t      send_blk [NDUT][MAXB];
    int          prod_wr [NDUT];
    int          prod_rd [NDUT];
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule: W[i] = s1(W[i-2]) + W[i-7] + s0(W[i-15]) + W[i-16]
    function automatic logic [31:0] model_w(input block_t b, input int idx);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = b[i];
            else begin
                s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
                s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
                w[i] = s1 + w[i-7] + s0 + w[i-16];
            end
        end
        return w[idx];
    endfunction

    // Input driver: changes inputs 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < NDUT; d++) begin
            drv_rdy[d] = (rdy_mode == 0) ? 1'b1 :
                         (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (prod_rd[d] < prod_wr[d]) begin
                drv_valid[d] = 1'b1;
                drv_blk[d]   = send_blk[d][prod_rd[d]];
            end else begin
                drv_valid[d] = 1'b0;
                for (int k = 0; k < 16; k++) drv_blk[d][k] = $urandom;
            end
        end
    end

    // Compare process: outputs checked against the model every falling edge
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            int  n;
            int  h;
            logic exp_rdy;
            if (rst) begin
                check("rst_valid", d, 32'(mon_valid[d]), 32'd0);
                check("rst_busy",  d, 32'(mon_busy[d]),  32'd0);
                check("rst_done",  d, 32'(mon_done[d]),  32'd0);
                exp_rd[d]    = exp_wr[d];
                pend_done[d] = 1'b0;
            end else begin
                n = exp_wr[d] - exp_rd[d];
                h = exp_rd[d] % QD;
                check("valid", d, 32'(mon_valid[d]), 32'(n > 0));
                check("busy",  d, 32'(mon_busy[d]),  32'(n > 0));
                check("done",  d, 32'(mon_done[d]),  32'(pend_done[d]));
                if (mon_done[d]) done_cnt[d]++;
                // Ready when nothing is queued, or (chaining) only the final word remains
                exp_rdy = (n == 0) || ((d == 0) && (n == 1) && (exp_t[d][h] == ROUNDS - 1));
                check("blk_ready", d, 32'(mon_ready[d]), 32'(exp_rdy));
                pend_done[d] = 1'b0;
                if (n > 0) begin
                    check("w",    d, mon_w[d], exp_w[d][h]);
                    check("t",    d, 32'(mon_t[d]), 32'(exp_t[d][h]));
                    check("last", d, 32'(mon_last[d]), 32'(exp_t[d][h] == ROUNDS - 1));
                    if (drv_rdy[d]) begin
                        if (exp_t[d][h] == ROUNDS - 1) pend_done[d] = 1'b1;
                        exp_rd[d]++;
                    end
                end
                if (drv_valid[d] && exp_rdy) begin
                    for (int k = 0; k < int'(ROUNDS); k++) begin
                        exp_w[d][exp_wr[d] % QD] = model_w(drv_blk[d], k);
                        exp_t[d][exp_wr[d] % QD] = k;
                        exp_wr[d]++;
                    end
                    prod_rd[d]++;
                end
            end
        end
    end

    task automatic send_both(input block_t b);
        for (int d = 0; d < NDUT; d++) begin
            send_blk[d][prod_wr[d]] = b;
            prod_wr[d]++;
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            @(negedge clk); #1;
            idle = 1'b1;
            for (int d = 0; d < NDUT; d++)
                if (prod_rd[d] != prod_wr[d] || exp_rd[d] != exp_wr[d] || pend_done[d]) idle = 1'b0;
        end
        check("wait_idle_timeout", 0, 32'(idle), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    function automatic block_t rand_block();
        block_t b;
        for (int k = 0; k < 16; k++) b[k] = $urandom;
        return b;
    endfunction

    initial begin
        block_t zb;
        block_t abc;
        bit     hit;
        zb  = '0;
        abc = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        for (int d = 0; d < NDUT; d++) begin
            drv_valid[d] = 1'b0; drv_rdy[d] = 1'b1; drv_blk[d] = '0;
            exp_wr[d] = 0; exp_rd[d] = 0; pend_done[d] = 1'b0; done_cnt[d] = 0;
            prod_wr[d] = 0; prod_rd[d] = 0;
        end

        // Hand-computed values pinning the reference model
        check("pin_abc_w0",  0, model_w(abc, 0),  32'h61626380);
        check("pin_abc_w15", 0, model_w(abc, 15), 32'h00000018);
        check("pin_abc_w16", 0, model_w(abc, 16), 32'h61626380);
        check("pin_abc_w17", 0, model_w(abc, 17), 32'h000F0000);
        check("pin_zero_w63", 0, model_w(zb, 63), 32'h00000000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        for (int d = 0; d < NDUT; d++) begin
            check("post_rst_ready", d, 32'(mon_ready[d]), 32'd1);
            check("post_rst_w",     d, mon_w[d], 32'd0);
            check("post_rst_t",     d, 32'(mon_t[d]), 32'd0);
        end

        rdy_mode = 0; send_both(zb);  wait_idle();
        rdy_mode = 0; send_both(abc); wait_idle();
        rdy_mode = 1; send_both(abc); wait_idle();
        rdy_mode = 0; send_both(rand_block()); send_both(rand_block()); wait_idle();
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) send_both(rand_block());
        wait_idle();

        // Asynchronous reset while stalled at t=20
        rdy_mode = 0; send_both(abc);
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk); #1;
            if (mon_valid[0] && mon_t[0] == 6'd19) hit = 1'b1;
        end
        check("reach_t19", 0, 32'(hit), 32'd1);
        rdy_mode = 2;
        @(posedge clk);
        @(posedge clk);
        #2;
        for (int d = 0; d < NDUT; d++) begin
            check("stall_t20", d, 32'(mon_t[d]), 32'd20);
            check("stall_w20", d, mon_w[d], model_w(abc, 20));
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("async_valid", d, 32'(mon_valid[d]), 32'd0);
            check("async_busy",  d, 32'(mon_busy[d]),  32'd0);
            check("async_done",  d, 32'(mon_done[d]),  32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        send_both(abc); wait_idle();

        for (int d = 0; d < NDUT; d++)
            check("done_count", d, 32'(done_cnt[d]), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_schedule_controller.md
Name: sha_schedule_controller

Overview:
Sequences SHA-256 message expansion for one 512-bit block at a time. It accepts a 16-word block over a valid/ready handshake. It then streams W_0..W_{ROUNDS-1} one word per accepted beat to the compression-round datapath, with round index and last flag. It sits between the block padder/buffer and the compression core, and replaces free-running expander pipelines when the core can stall.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.
BACK_TO_BACK, 1, if 1 the next block may be accepted in the same cycle as the last-word handshake; if 0 a block is accepted only in IDLE.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
blk_valid_i  input  1  block available
blk_ready_o  output  1  controller can accept a block this cycle
blk_i  input  16x32  message block; blk_i[0] = W_0 (first big-endian word)
w_valid_o  output  1  w_o/t_o/last_o valid
w_ready_i  input  1  consumer accepts current word
w_o  output  32  schedule word W_t
t_o  output  6  round index t
last_o  output  1  high with t_o == ROUNDS-1
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse, the cycle after the last-word handshake

Behaviour:
- Reset (asynchronous, any time including mid-block):
  - state=IDLE; window, counter and all outputs 0.
  - blk_ready_o is 1 after reset deasserts; w_valid_o, done_o, busy_o are 0.
  - A partially streamed block is discarded and no done_o is issued.
- Internal 16x32 window win[0..15]; win[0] always holds W_t.
- States: IDLE, RUN.
- IDLE: blk_ready_o=1. On blk_valid_i && blk_ready_o: win <= blk_i, t <= 0, go to RUN.
- First word latency: w_valid_o=1 with W_0 in the cycle after acceptance.
- RUN: w_valid_o=1, w_o=win[0], t_o=t, last_o=(t==ROUNDS-1).
  - Outputs hold stable while w_ready_i=0, with no bubbles.
- Beat = w_valid_o && w_ready_i. On a beat with t<ROUNDS-1:
  - win[i] <= win[i+1] for i=0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32. This is W_{t+16}.
  - t <= t+1.
  - Words computed for t+16 >= ROUNDS are never emitted and need not be correct.
- sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3. sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Last beat (t==ROUNDS-1):
  - done_o=1 in the next cycle.
  - BACK_TO_BACK=0: go to IDLE.
  - BACK_TO_BACK=1: blk_ready_o=1 in RUN iff last_o. If blk_valid_i is also high in that cycle, load win/t from the new block and stay in RUN, so W_0 of the new block appears the next cycle with no gap. done_o still pulses for the finished block. Otherwise go to IDLE.
- blk_ready_o is combinational from state, t and last_o only. It must not depend on blk_valid_i.
- blk_i is sampled only on acceptance; later changes are ignored.
- t_o width is 6 bits, so ROUNDS<=64. Counter never wraps; it is reloaded only on acceptance.
- Throughput: one word per cycle when w_ready_i is held high. A block takes ROUNDS cycles, plus 1 idle cycle when BACK_TO_BACK=0.

Decomposition:
- Package sha_schedule_pkg:
  - word_t (logic[31:0]); block_t (logic[15:0][31:0]).
  - State enum {IDLE, RUN}; constant SHA256_ROUNDS=64.
  - Functions sigma0 and sigma1.
- Sub-module sha_schedule_step: combinational, input block_t window, output word_t next.
  - Computes the win[15] update; kept separate so it can be unit-tested and shared with the compression core's checker.

Test Plan:
- All-zero block, w_ready_i=1: 64 beats, all w_o=0x00000000, t_o 0..63, last_o only at t=63, done_o at cycle 65 after acceptance.
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready_i=1:
  - t=0 gives 0x61626380, t=15 gives 0x00000018.
  - t=16 gives 0x61626380, t=17 gives 0x000F0000.
  - t=16..63 match a golden model.
- Same "abc" block with w_ready_i randomly toggled 50%: w_o/t_o hold while stalled, and the word sequence is identical to the unstalled run.
- BACK_TO_BACK=1, two blocks presented continuously:
  - Second block accepted on the t=63 beat; next cycle shows t_o=0 with the second block's W_0.
  - done_o pulses once per block; busy_o never drops.
- BACK_TO_BACK=0, same stimulus: one IDLE cycle between blocks (blk_ready_o=1, w_valid_o=0).
- Assert rst asynchronously at t=20 mid-stall:
  - w_valid_o, busy_o, done_o go 0 immediately without waiting for a clock edge, and stay 0 until a new block is accepted.
  - Next block restarts at t_o=0 with correct words.
